// File: rtl/zero_skip_packer_if.sv
// Stream-in / BRAM-write-out bundle for the zero-skip packer.
// The packer is the slave on the stream side and drives the BRAM write port.
interface zero_skip_packer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]      s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
    logic [BRAM_DATA_WIDTH-1:0] bram_wrdata;
    logic [DATA_WIDTH/8-1:0]    bram_we;

    modport master (
        output s_data, s_valid,
        input  s_ready, bram_addr, bram_wrdata, bram_we
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, bram_addr, bram_wrdata, bram_we
    );
endinterface

// File: rtl/zero_skip_packer.sv
// Packs a dense 8x8 A (nonzeros, 4 slots/row) + dense 8x8 B + 64-bit nonzero mask into BRAM.
// Define ZSP_ZERO_FILL_EN to explicitly zero unused A slots through the FILL state.
module zero_skip_packer #(
    parameter int DATA_WIDTH       = 32,
    parameter int BRAM_ADDR_WIDTH  = 15,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int LINE_SIZE        = 8,
    parameter int DONE_STATE_CYCLE = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    zero_skip_packer_if.slave    bus,
    output logic                 done,
    output logic                 overflow
);
    localparam int SLOTS      = LINE_SIZE / 2;
    localparam int RW         = $clog2(LINE_SIZE);
    localparam int SW         = $clog2(SLOTS + 1);
    localparam int A_WORDS    = LINE_SIZE * SLOTS;
    localparam int B_WORDS    = LINE_SIZE * LINE_SIZE;
    localparam int MASK_BASE  = A_WORDS + B_WORDS;
    localparam int WW         = $clog2(MASK_BASE + 2);
    localparam int BW         = $clog2(B_WORDS);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int DCW        = $clog2(DONE_STATE_CYCLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADA,
`ifdef ZSP_ZERO_FILL_EN
        ST_FILL,
`endif
        ST_LOADB,
        ST_MASK0,
        ST_MASK1,
        ST_DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [RW-1:0]               row_reg, row_next;
    logic [RW-1:0]               col_reg, col_next;
    logic [SW-1:0]               slot_reg, slot_next, slot_after;
    logic [BW-1:0]               bidx_reg, bidx_next;
    logic [B_WORDS-1:0]          mask_reg, mask_next;
    logic                        ovf_reg, ovf_next;
    logic [BRAM_ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [BRAM_DATA_WIDTH-1:0]  wrdata_reg, wrdata_next;
    logic [DATA_WIDTH/8-1:0]     we_reg, we_next;
    logic [DCW-1:0]              dcnt_reg, dcnt_next;
    logic                        accept;
    logic [WW-1:0]               a_word;

    function automatic logic [BRAM_ADDR_WIDTH-1:0] word_addr(input logic [WW-1:0] w);
        return BRAM_ADDR_WIDTH'(w) << BYTE_SHIFT;
    endfunction

    assign bus.s_ready    = (state_reg == ST_LOADA) || (state_reg == ST_LOADB);
    assign bus.bram_addr   = addr_reg;
    assign bus.bram_wrdata = wrdata_reg;
    assign bus.bram_we     = we_reg;
    assign done            = (state_reg == ST_DONE);
    assign overflow        = ovf_reg;
    assign accept          = bus.s_valid && bus.s_ready;
    assign a_word          = WW'(row_reg) * WW'(SLOTS) + WW'(slot_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            row_reg    <= '0;
            col_reg    <= '0;
            slot_reg   <= '0;
            bidx_reg   <= '0;
            mask_reg   <= '0;
            ovf_reg    <= 1'b0;
            addr_reg   <= '0;
            wrdata_reg <= '0;
            we_reg     <= '0;
            dcnt_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            slot_reg   <= slot_next;
            bidx_reg   <= bidx_next;
            mask_reg   <= mask_next;
            ovf_reg    <= ovf_next;
            addr_reg   <= addr_next;
            wrdata_reg <= wrdata_next;
            we_reg     <= we_next;
            dcnt_reg   <= dcnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        slot_next   = slot_reg;
        slot_after  = slot_reg;
        bidx_next   = bidx_reg;
        mask_next   = mask_reg;
        ovf_next    = ovf_reg;
        addr_next   = addr_reg;
        wrdata_next = wrdata_reg;
        we_next     = '0;
        dcnt_next   = dcnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOADA;
                    row_next   = '0;
                    col_next   = '0;
                    slot_next  = '0;
                    bidx_next  = '0;
                    mask_next  = '0;
                    ovf_next   = 1'b0;
                end
            end
            ST_LOADA: begin
                if (accept) begin
                    // Any set bit counts as nonzero, including a lone sign bit.
                    if (bus.s_data != '0) begin
                        if (slot_reg < SW'(SLOTS)) begin
                            we_next                     = '1;
                            addr_next                   = word_addr(a_word);
                            wrdata_next                 = BRAM_DATA_WIDTH'(bus.s_data);
                            mask_next[{row_reg, col_reg}] = 1'b1;
                            slot_after                  = slot_reg + 1'b1;
                        end else begin
                            ovf_next = 1'b1;
                        end
                    end
                    slot_next = slot_after;
                    col_next  = col_reg + 1'b1;
                    if (col_reg == RW'(LINE_SIZE - 1)) begin
                        slot_next = '0;
                        if (row_reg == RW'(LINE_SIZE - 1)) state_next = ST_LOADB;
                        else                               row_next   = row_reg + 1'b1;
`ifdef ZSP_ZERO_FILL_EN
                        // Row finished short: pad it before moving on.
                        if (slot_after < SW'(SLOTS)) begin
                            state_next = ST_FILL;
                            slot_next  = slot_after;
                            row_next   = row_reg;
                        end
`endif
                    end
                end
            end
`ifdef ZSP_ZERO_FILL_EN
            ST_FILL: begin
                we_next     = '1;
                addr_next   = word_addr(a_word);
                wrdata_next = '0;
                slot_next   = slot_reg + 1'b1;
                if (slot_reg == SW'(SLOTS - 1)) begin
                    slot_next = '0;
                    if (row_reg == RW'(LINE_SIZE - 1)) begin
                        state_next = ST_LOADB;
                    end else begin
                        state_next = ST_LOADA;
                        row_next   = row_reg + 1'b1;
                    end
                end
            end
`endif
            ST_LOADB: begin
                if (accept) begin
                    we_next     = '1;
                    addr_next   = word_addr(WW'(A_WORDS) + WW'(bidx_reg));
                    wrdata_next = BRAM_DATA_WIDTH'(bus.s_data);
                    bidx_next   = bidx_reg + 1'b1;
                    if (bidx_reg == BW'(B_WORDS - 1)) state_next = ST_MASK0;
                end
            end
            ST_MASK0: begin
                we_next     = '1;
                addr_next   = word_addr(WW'(MASK_BASE));
                wrdata_next = mask_reg[BRAM_DATA_WIDTH-1:0];
                state_next  = ST_MASK1;
            end
            ST_MASK1: begin
                we_next     = '1;
                addr_next   = word_addr(WW'(MASK_BASE + 1));
                wrdata_next = mask_reg[2*BRAM_DATA_WIDTH-1:BRAM_DATA_WIDTH];
                state_next  = ST_DONE;
                dcnt_next   = '0;
            end
            ST_DONE: begin
                dcnt_next = dcnt_reg + 1'b1;
                if (dcnt_reg == DCW'(DONE_STATE_CYCLE - 1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule
